// File: rtl/pipe_control_unit_if.sv
// pipe_control_unit_if: groups the IF/ID-side inputs and the control outputs
// of pipe_control_unit. The master side drives instructions and pipe events,
// and the slave side (the control unit) returns the stall, control words and halt.
interface pipe_control_unit_if #(
   parameter int STAGES = 3,
   parameter int CW_W   = 20
);
   logic [31:0]             instr_i;
   logic                    instr_valid_i;
   logic                    mem_stall_i;
   logic                    flush_i;
   logic                    stall_o;
   logic [STAGES*CW_W-1:0]  ctrl_o;
   logic                    halt_o;

   modport master (
      output instr_i, instr_valid_i, mem_stall_i, flush_i,
      input  stall_o, ctrl_o, halt_o
   );

   modport slave (
      input  instr_i, instr_valid_i, mem_stall_i, flush_i,
      output stall_o, ctrl_o, halt_o
   );
endinterface

// File: rtl/pipe_control_unit.sv
// pipe_control_unit: decodes the IF/ID instruction into a 20-bit control word
// and carries it down a STAGES-deep delay line (entry 0 = EX, STAGES-1 = WB).
// Handles load-use bubbles, branch/jump flushes and memory freezes.
// Optional feature macro: CU_HALT_EN (HALT opcode 0x3F drains the pipe and
// raises a sticky halt_o). Without it 0x3F is an unknown opcode and halt_o = 0.
module pipe_control_unit #(
   parameter int STAGES = 3,   // legal 2..6
   parameter int CW_W   = 20   // must match the control word layout
) (
   input  logic               CLK,
   input  logic               nRST,
   pipe_control_unit_if.slave cu
);
   // ALU operation codes of the core
   localparam logic [3:0] ALU_ADD  = 4'd0;
   localparam logic [3:0] ALU_SUB  = 4'd1;
   localparam logic [3:0] ALU_AND  = 4'd2;
   localparam logic [3:0] ALU_OR   = 4'd3;
   localparam logic [3:0] ALU_XOR  = 4'd4;
   localparam logic [3:0] ALU_NOR  = 4'd5;
   localparam logic [3:0] ALU_SLT  = 4'd6;
   localparam logic [3:0] ALU_SLTU = 4'd7;
   localparam logic [3:0] ALU_SLL  = 4'd8;
   localparam logic [3:0] ALU_SRL  = 4'd9;

   // Field encodings (zero values are rt / ALU result / sequential PC)
   localparam logic [1:0] SRC_IMM   = 2'd1;
   localparam logic [1:0] SRC_SHAMT = 2'd2;
   localparam logic [1:0] SEL_PC4   = 2'd1;
   localparam logic [1:0] SEL_LUI   = 2'd2;
   localparam logic [1:0] SEL_MEM   = 2'd3;
   localparam logic [1:0] PC_JR     = 2'd1;
   localparam logic [1:0] PC_JUMP   = 2'd2;
   localparam logic [1:0] PC_BR     = 2'd3;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ADDIU = 6'h09;
   localparam logic [5:0] OP_SLTI  = 6'h0A;
   localparam logic [5:0] OP_SLTIU = 6'h0B;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_XORI  = 6'h0E;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
`ifdef CU_HALT_EN
   localparam logic [5:0] OP_HALT  = 6'h3F;
`endif

   localparam logic [5:0] FN_SLL  = 6'h00;
   localparam logic [5:0] FN_SRL  = 6'h02;
   localparam logic [5:0] FN_JR   = 6'h08;
   localparam logic [5:0] FN_ADD  = 6'h20;
   localparam logic [5:0] FN_ADDU = 6'h21;
   localparam logic [5:0] FN_SUB  = 6'h22;
   localparam logic [5:0] FN_SUBU = 6'h23;
   localparam logic [5:0] FN_AND  = 6'h24;
   localparam logic [5:0] FN_OR   = 6'h25;
   localparam logic [5:0] FN_XOR  = 6'h26;
   localparam logic [5:0] FN_NOR  = 6'h27;
   localparam logic [5:0] FN_SLT  = 6'h2A;
   localparam logic [5:0] FN_SLTU = 6'h2B;

   // MSB -> LSB layout of one control word
   typedef struct packed {
      logic       valid;
      logic       reg_wr;
      logic [1:0] alu_src;
      logic [1:0] reg_sel;
      logic [1:0] pc_src;
      logic [4:0] reg_dst;
      logic       ext_op;
      logic       d_wen;
      logic       d_ren;
      logic [3:0] alu_op;
   } cw_t;

   cw_t [STAGES-1:0] cw_q, cw_d;
   cw_t              dec;
   logic             rd_rs, rd_rt, dec_halt;
   logic             ld_hzd, drain, kill;
   logic [5:0]       op, funct;
   logic [4:0]       rs, rt, rd;
   logic             unused_shamt;

   assign op           = cu.instr_i[31:26];
   assign rs           = cu.instr_i[25:21];
   assign rt           = cu.instr_i[20:16];
   assign rd           = cu.instr_i[15:11];
   assign funct        = cu.instr_i[5:0];
   // shamt is consumed by the datapath straight from IF/ID, not by control
   assign unused_shamt = ^cu.instr_i[10:6];

   // Combinational decode; rd_rs/rd_rt flag which source registers are read
   always_comb begin
      dec      = '0;
      rd_rs    = 1'b0;
      rd_rt    = 1'b0;
      dec_halt = 1'b0;
      if (cu.instr_valid_i) begin
         case (op)
            OP_RTYPE: begin
               dec.valid   = 1'b1;
               dec.reg_wr  = 1'b1;
               dec.reg_dst = rd;
               rd_rs       = 1'b1;
               rd_rt       = 1'b1;
               case (funct)
                  FN_SLL:          begin dec.alu_src = SRC_SHAMT; dec.alu_op = ALU_SLL; rd_rs = 1'b0; end
                  FN_SRL:          begin dec.alu_src = SRC_SHAMT; dec.alu_op = ALU_SRL; rd_rs = 1'b0; end
                  FN_JR:           begin dec.reg_wr = 1'b0; dec.reg_dst = 5'd0; dec.pc_src = PC_JR; rd_rt = 1'b0; end
                  FN_ADD, FN_ADDU: dec.alu_op = ALU_ADD;
                  FN_SUB, FN_SUBU: dec.alu_op = ALU_SUB;
                  FN_AND:          dec.alu_op = ALU_AND;
                  FN_OR:           dec.alu_op = ALU_OR;
                  FN_XOR:          dec.alu_op = ALU_XOR;
                  FN_NOR:          dec.alu_op = ALU_NOR;
                  FN_SLT:          dec.alu_op = ALU_SLT;
                  FN_SLTU:         dec.alu_op = ALU_SLTU;
                  default:         begin dec = '0; rd_rs = 1'b0; rd_rt = 1'b0; end
               endcase
            end
            OP_J: begin
               dec.valid  = 1'b1;
               dec.pc_src = PC_JUMP;
            end
            OP_JAL: begin
               dec.valid   = 1'b1;
               dec.reg_wr  = 1'b1;
               dec.reg_sel = SEL_PC4;
               dec.pc_src  = PC_JUMP;
               dec.reg_dst = 5'd31;
            end
            OP_BEQ, OP_BNE: begin
               dec.valid   = 1'b1;
               dec.pc_src  = PC_BR;
               dec.reg_dst = rt;
               dec.alu_op  = ALU_SUB;
               rd_rs       = 1'b1;
               rd_rt       = 1'b1;
            end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI: begin
               dec.valid   = 1'b1;
               dec.reg_wr  = 1'b1;
               dec.alu_src = SRC_IMM;
               dec.reg_dst = rt;
               rd_rs       = 1'b1;
               case (op)
                  OP_SLTI:  begin dec.alu_op = ALU_SLT; dec.ext_op = 1'b1; end
                  OP_SLTIU: dec.alu_op = ALU_SLTU;
                  OP_ANDI:  dec.alu_op = ALU_AND;
                  OP_ORI:   dec.alu_op = ALU_OR;
                  OP_XORI:  dec.alu_op = ALU_XOR;
                  default:  begin dec.alu_op = ALU_ADD; dec.ext_op = 1'b1; end
               endcase
            end
            OP_LUI: begin
               dec.valid   = 1'b1;
               dec.reg_wr  = 1'b1;
               dec.alu_src = SRC_IMM;
               dec.reg_sel = SEL_LUI;
               dec.reg_dst = rt;
            end
            OP_LW: begin
               dec.valid   = 1'b1;
               dec.reg_wr  = 1'b1;
               dec.alu_src = SRC_IMM;
               dec.reg_sel = SEL_MEM;
               dec.reg_dst = rt;
               dec.ext_op  = 1'b1;
               dec.d_ren   = 1'b1;
               dec.alu_op  = ALU_ADD;
               rd_rs       = 1'b1;
            end
            OP_SW: begin
               dec.valid   = 1'b1;
               dec.alu_src = SRC_IMM;
               dec.reg_dst = rt;
               dec.ext_op  = 1'b1;
               dec.d_wen   = 1'b1;
               dec.alu_op  = ALU_ADD;
               rd_rs       = 1'b1;
               rd_rt       = 1'b1;
            end
`ifdef CU_HALT_EN
            OP_HALT: begin
               dec.valid = 1'b1;
               dec_halt  = 1'b1;
            end
`endif
            default: ;
         endcase
      end
   end

   // A load in EX whose target is read by the IF/ID instruction
   assign ld_hzd = cw_q[0].valid & cw_q[0].d_ren & (cw_q[0].reg_dst != 5'd0) &
                   ((rd_rs & (cw_q[0].reg_dst == rs)) | (rd_rt & (cw_q[0].reg_dst == rt)));

`ifdef CU_HALT_EN
   logic [STAGES-1:0] hlt_q, hlt_d;
   logic              halt_q, halt_d;

   // Once a HALT is in flight (or retired) only bubbles enter the pipe
   assign drain     = (|hlt_q) | halt_q;
   assign cu.halt_o = halt_q;

   // Halt marker follows its word down the line; halt_o latches as it leaves WB
   always_comb begin
      hlt_d  = hlt_q;
      halt_d = halt_q;
      if (!cu.mem_stall_i) begin
         hlt_d  = {hlt_q[STAGES-2:0], dec_halt & ~kill};
         halt_d = halt_q | hlt_q[STAGES-1];
      end
   end

   // Halt tracking registers
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         hlt_q  <= '0;
         halt_q <= 1'b0;
      end else begin
         hlt_q  <= hlt_d;
         halt_q <= halt_d;
      end
   end
`else
   assign drain     = 1'b0;
   assign cu.halt_o = 1'b0;
`endif

   // Anything that replaces the decoded word with a bubble in entry 0
   assign kill = cu.flush_i | ld_hzd | drain;

   // A flushed instruction needs no stall; a decoded or in-flight HALT always holds
   assign cu.stall_o = drain | (~cu.flush_i & (ld_hzd | dec_halt));

   // Advance the delay line unless memory freezes the whole pipe
   always_comb begin
      cw_d = cw_q;
      if (!cu.mem_stall_i) begin
         for (int k = STAGES-1; k > 0; k--) cw_d[k] = cw_q[k-1];
         cw_d[0] = kill ? cw_t'('0) : dec;
      end
   end

   // Control word delay line, cleared asynchronously
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) cw_q <= '0;
      else       cw_q <= cw_d;
   end

   assign cu.ctrl_o = cw_q;

endmodule

// File: tb/tb_pipe_control_unit.sv
// tb_pipe_control_unit: directed vector table, multi-cycle corner sequences,
// then random traffic checked against a queue-based model of the control pipe.
module tb_pipe_control_unit;
   localparam int STAGES = 3;
   localparam int CW_W   = 20;

   localparam logic [3:0] A_ADD = 4'd0, A_SUB = 4'd1, A_AND = 4'd2, A_OR = 4'd3,
                          A_XOR = 4'd4, A_NOR = 4'd5, A_SLT = 4'd6, A_SLTU = 4'd7,
                          A_SLL = 4'd8, A_SRL = 4'd9;

   typedef struct packed {
      logic v; logic rw; logic [1:0] asrc; logic [1:0] rsel; logic [1:0] pcs;
      logic [4:0] dst; logic ext; logic wen; logic ren; logic [3:0] aop;
   } word_t;

   typedef struct {
      logic [31:0] ins; logic v; logic ms; logic fl; logic st;
      word_t e0; word_t e1; word_t e2;
   } vec_t;

   logic CLK = 1'b0;
   logic nRST = 1'b1;
   int   n_chk = 0;
   int   n_fail = 0;
   word_t m_q[$];
   vec_t  tbl[26];

   pipe_control_unit_if #(.STAGES(STAGES), .CW_W(CW_W)) bus();
   pipe_control_unit #(.STAGES(STAGES), .CW_W(CW_W)) dut (.CLK(CLK), .nRST(nRST), .cu(bus));

   always #5 CLK = ~CLK;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, n_chk=%0d", n_chk);
      $fatal(1, "timeout");
   end

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic word_t mk(input logic rw, input logic [1:0] asrc, input logic [1:0] rsel,
                                input logic [1:0] pcs, input logic [4:0] dst, input logic ext,
                                input logic wen, input logic ren, input logic [3:0] aop);
      return {1'b1, rw, asrc, rsel, pcs, dst, ext, wen, ren, aop};
   endfunction

   // Reference decode written from the instruction table: word plus source-read flags
   function automatic void ref_decode(input logic [31:0] ins, input logic v, output word_t w,
                                      output logic urs, output logic urt);
      logic [5:0] op = ins[31:26];
      logic [5:0] fn = ins[5:0];
      logic [4:0] rt = ins[20:16];
      logic [4:0] rd = ins[15:11];
      w = '0; urs = 1'b0; urt = 1'b0;
      if (v) begin
         case (op)
            6'h00: begin
               case (fn)
                  6'h00: w = mk(1'b1, 2'd2, 2'd0, 2'd0, rd, 1'b0, 1'b0, 1'b0, A_SLL);
                  6'h02: w = mk(1'b1, 2'd2, 2'd0, 2'd0, rd, 1'b0, 1'b0, 1'b0, A_SRL);
                  6'h08: w = mk(1'b0, 2'd0, 2'd0, 2'd1, 5'd0, 1'b0, 1'b0, 1'b0, A_ADD);
                  6'h20, 6'h21: w = mk(1'b1, 2'd0, 2'd0, 2'd0, rd, 1'b0, 1'b0, 1'b0, A_ADD);
                  6'h22, 6'h23: w = mk(1'b1, 2'd0, 2'd0, 2'd0, rd, 1'b0, 1'b0, 1'b0, A_SUB);
                  6'h24: w = mk(1'b1, 2'd0, 2'd0, 2'd0, rd, 1'b0, 1'b0, 1'b0, A_AND);
                  6'h25: w = mk(1'b1, 2'd0, 2'd0, 2'd0, rd, 1'b0, 1'b0, 1'b0, A_OR);
                  6'h26: w = mk(1'b1, 2'd0, 2'd0, 2'd0, rd, 1'b0, 1'b0, 1'b0, A_XOR);
                  6'h27: w = mk(1'b1, 2'd0, 2'd0, 2'd0, rd, 1'b0, 1'b0, 1'b0, A_NOR);
                  6'h2A: w = mk(1'b1, 2'd0, 2'd0, 2'd0, rd, 1'b0, 1'b0, 1'b0, A_SLT);
                  6'h2B: w = mk(1'b1, 2'd0, 2'd0, 2'd0, rd, 1'b0, 1'b0, 1'b0, A_SLTU);
                  default: w = '0;
               endcase
               urs = w.v && fn != 6'h00 && fn != 6'h02;
               urt = w.v && fn != 6'h08;
            end
            6'h02: w = mk(1'b0, 2'd0, 2'd0, 2'd2, 5'd0, 1'b0, 1'b0, 1'b0, A_ADD);
            6'h03: w = mk(1'b1, 2'd0, 2'd1, 2'd2, 5'd31, 1'b0, 1'b0, 1'b0, A_ADD);
            6'h04, 6'h05: begin w = mk(1'b0, 2'd0, 2'd0, 2'd3, rt, 1'b0, 1'b0, 1'b0, A_SUB); urs = 1'b1; urt = 1'b1; end
            6'h08, 6'h09: begin w = mk(1'b1, 2'd1, 2'd0, 2'd0, rt, 1'b1, 1'b0, 1'b0, A_ADD); urs = 1'b1; end
            6'h0A: begin w = mk(1'b1, 2'd1, 2'd0, 2'd0, rt, 1'b1, 1'b0, 1'b0, A_SLT); urs = 1'b1; end
            6'h0B: begin w = mk(1'b1, 2'd1, 2'd0, 2'd0, rt, 1'b0, 1'b0, 1'b0, A_SLTU); urs = 1'b1; end
            6'h0C: begin w = mk(1'b1, 2'd1, 2'd0, 2'd0, rt, 1'b0, 1'b0, 1'b0, A_AND); urs = 1'b1; end
            6'h0D: begin w = mk(1'b1, 2'd1, 2'd0, 2'd0, rt, 1'b0, 1'b0, 1'b0, A_OR); urs = 1'b1; end
            6'h0E: begin w = mk(1'b1, 2'd1, 2'd0, 2'd0, rt, 1'b0, 1'b0, 1'b0, A_XOR); urs = 1'b1; end
            6'h0F: w = mk(1'b1, 2'd1, 2'd2, 2'd0, rt, 1'b0, 1'b0, 1'b0, A_ADD);
            6'h23: begin w = mk(1'b1, 2'd1, 2'd3, 2'd0, rt, 1'b1, 1'b0, 1'b1, A_ADD); urs = 1'b1; end
            6'h2B: begin w = mk(1'b0, 2'd1, 2'd0, 2'd0, rt, 1'b1, 1'b1, 1'b0, A_ADD); urs = 1'b1; urt = 1'b1; end
            default: w = '0;
         endcase
      end
   endfunction

   function automatic logic [STAGES*CW_W-1:0] pack_model();
      logic [STAGES*CW_W-1:0] r = '0;
      for (int k = 0; k < STAGES; k++) r[k*CW_W +: CW_W] = m_q[k];
      return r;
   endfunction

   function automatic logic [31:0] rnd_instr();
      logic [5:0] op, fn;
      logic [4:0] rs, rt, rd, sh;
      logic [15:0] imm;
      rs  = 5'($urandom_range(0, 3));
      rt  = 5'($urandom_range(0, 3));
      rd  = 5'($urandom_range(0, 3));
      sh  = 5'($urandom);
      imm = 16'($urandom);
      case ($urandom_range(0, 19))
         0, 1, 2, 3: op = 6'h00;
         4: op = 6'h02;  5: op = 6'h03;  6: op = 6'h04;  7: op = 6'h05;
         8: op = 6'h08;  9: op = 6'h09; 10: op = 6'h0A; 11: op = 6'h0B;
         12: op = 6'h0C; 13: op = 6'h0D; 14: op = 6'h0E; 15: op = 6'h0F;
         16, 17: op = 6'h23; 18: op = 6'h2B;
         default: op = 6'h3E;
      endcase
      case ($urandom_range(0, 13))
         0: fn = 6'h00; 1: fn = 6'h02; 2: fn = 6'h08; 3: fn = 6'h20; 4: fn = 6'h21;
         5: fn = 6'h22; 6: fn = 6'h23; 7: fn = 6'h24; 8: fn = 6'h25; 9: fn = 6'h26;
         10: fn = 6'h27; 11: fn = 6'h2A; 12: fn = 6'h2B; default: fn = 6'h3F;
      endcase
      if (op == 6'h00) return {op, rs, rt, rd, sh, fn};
      return {op, rs, rt, imm};
   endfunction

   // One clock: drive at negedge, sample stall_o before the edge, leave #1 after it
   task automatic drive_cycle(input logic [31:0] ins, input logic v, input logic ms,
                              input logic fl, output logic st);
      @(negedge CLK);
      bus.instr_i = ins; bus.instr_valid_i = v; bus.mem_stall_i = ms; bus.flush_i = fl;
      #1 st = bus.stall_o;
      @(posedge CLK);
      #1;
   endtask

   task automatic reset_dut();
      @(negedge CLK);
      bus.instr_i = '0; bus.instr_valid_i = 1'b0; bus.mem_stall_i = 1'b0; bus.flush_i = 1'b0;
      nRST = 1'b0;
      @(negedge CLK);
      nRST = 1'b1;
      m_q.delete();
      for (int k = 0; k < STAGES; k++) m_q.push_back('0);
   endtask

   initial begin
      word_t W_ADDI, W_LW9, W_ADD, W_LW0, W_ADD0, W_BEQ, W_JAL, W_JR, Z;
      logic [31:0] I_ADDI, I_LW9, I_ADD, I_LW0, I_ADD0, I_BEQ, I_SW, I_JAL, I_JR;
      logic st;

      I_ADDI = 32'h20010005; I_LW9 = 32'h8C090000; I_ADD = 32'h01295020;
      I_LW0  = 32'h8C000000; I_ADD0 = 32'h00005020; I_BEQ = 32'h10220004;
      I_SW   = 32'hAC030000; I_JAL = 32'h0C000010; I_JR  = 32'h03E00008;
      Z      = '0;
      W_ADDI = mk(1'b1, 2'd1, 2'd0, 2'd0, 5'd1,  1'b1, 1'b0, 1'b0, A_ADD);
      W_LW9  = mk(1'b1, 2'd1, 2'd3, 2'd0, 5'd9,  1'b1, 1'b0, 1'b1, A_ADD);
      W_ADD  = mk(1'b1, 2'd0, 2'd0, 2'd0, 5'd10, 1'b0, 1'b0, 1'b0, A_ADD);
      W_LW0  = mk(1'b1, 2'd1, 2'd3, 2'd0, 5'd0,  1'b1, 1'b0, 1'b1, A_ADD);
      W_ADD0 = W_ADD;
      W_BEQ  = mk(1'b0, 2'd0, 2'd0, 2'd3, 5'd2,  1'b0, 1'b0, 1'b0, A_SUB);
      W_JAL  = mk(1'b1, 2'd0, 2'd1, 2'd2, 5'd31, 1'b0, 1'b0, 1'b0, A_ADD);
      W_JR   = mk(1'b0, 2'd0, 2'd0, 2'd1, 5'd0,  1'b0, 1'b0, 1'b0, A_ADD);

      //               ins     v     ms    fl    st    e0      e1      e2
      tbl[0]  = '{I_ADDI, 1'b1, 1'b0, 1'b0, 1'b0, W_ADDI, Z,      Z};
      tbl[1]  = '{32'h0,  1'b0, 1'b0, 1'b0, 1'b0, Z,      W_ADDI, Z};
      tbl[2]  = '{32'h0,  1'b0, 1'b0, 1'b0, 1'b0, Z,      Z,      W_ADDI};
      tbl[3]  = '{I_LW9,  1'b1, 1'b0, 1'b0, 1'b0, W_LW9,  Z,      Z};
      tbl[4]  = '{I_ADD,  1'b1, 1'b0, 1'b0, 1'b1, Z,      W_LW9,  Z};
      tbl[5]  = '{I_ADD,  1'b1, 1'b0, 1'b0, 1'b0, W_ADD,  Z,      W_LW9};
      tbl[6]  = '{I_LW0,  1'b1, 1'b0, 1'b0, 1'b0, W_LW0,  W_ADD,  Z};
      tbl[7]  = '{I_ADD0, 1'b1, 1'b0, 1'b0, 1'b0, W_ADD0, W_LW0,  W_ADD};
      tbl[8]  = '{I_BEQ,  1'b1, 1'b0, 1'b0, 1'b0, W_BEQ,  W_ADD0, W_LW0};
      tbl[9]  = '{I_SW,   1'b1, 1'b0, 1'b1, 1'b0, Z,      W_BEQ,  W_ADD0};
      tbl[10] = '{I_JAL,  1'b1, 1'b0, 1'b0, 1'b0, W_JAL,  Z,      W_BEQ};
      tbl[11] = '{I_JR,   1'b1, 1'b0, 1'b0, 1'b0, W_JR,   W_JAL,  Z};
      tbl[12] = '{I_LW9,  1'b1, 1'b0, 1'b0, 1'b0, W_LW9,  W_JR,   W_JAL};
      tbl[13] = '{I_ADD,  1'b1, 1'b0, 1'b1, 1'b0, Z,      W_LW9,  W_JR};
      tbl[14] = '{I_LW9,  1'b1, 1'b0, 1'b0, 1'b0, W_LW9,  Z,      W_LW9};
      tbl[15] = '{I_ADD,  1'b1, 1'b1, 1'b0, 1'b1, W_LW9,  Z,      W_LW9};
      tbl[16] = '{I_ADD,  1'b1, 1'b0, 1'b0, 1'b1, Z,      W_LW9,  Z};
      tbl[17] = '{I_ADD,  1'b1, 1'b0, 1'b0, 1'b0, W_ADD,  Z,      W_LW9};
      tbl[18] = '{I_ADDI, 1'b1, 1'b0, 1'b0, 1'b0, W_ADDI, W_ADD,  Z};
      tbl[19] = '{I_JAL,  1'b1, 1'b0, 1'b0, 1'b0, W_JAL,  W_ADDI, W_ADD};
      tbl[20] = '{I_ADD,  1'b1, 1'b0, 1'b0, 1'b0, W_ADD,  W_JAL,  W_ADDI};
      for (int r = 21; r < 25; r++)
         tbl[r] = '{I_ADDI, 1'b1, 1'b1, 1'b0, 1'b0, W_ADD, W_JAL, W_ADDI};
      tbl[25] = '{I_ADDI, 1'b1, 1'b0, 1'b0, 1'b0, W_ADDI, W_ADD,  W_JAL};

      // Reset state
      bus.instr_i = '0; bus.instr_valid_i = 1'b0; bus.mem_stall_i = 1'b0; bus.flush_i = 1'b0;
      #2 nRST = 1'b0;
      #1;
      check("reset_ctrl",  64'(bus.ctrl_o), 64'd0);
      check("reset_stall", 64'(bus.stall_o), 64'd0);
      check("reset_halt",  64'(bus.halt_o), 64'd0);
      @(negedge CLK);
      nRST = 1'b1;

      // Directed vector table
      for (int i = 0; i < 26; i++) begin
         drive_cycle(tbl[i].ins, tbl[i].v, tbl[i].ms, tbl[i].fl, st);
         check($sformatf("tbl%0d_stall", i), 64'(st), 64'(tbl[i].st));
         check($sformatf("tbl%0d_ctrl", i), 64'(bus.ctrl_o),
               64'({tbl[i].e2, tbl[i].e1, tbl[i].e0}));
      end

`ifdef CU_HALT_EN
      // HALT: stall from decode, halt_o once HALT leaves the last entry, sticky
      reset_dut();
      @(negedge CLK);
      bus.instr_i = 32'hFC000000; bus.instr_valid_i = 1'b1;
      #1 check("halt_stall_decode", 64'(bus.stall_o), 64'd1);
      for (int e = 1; e <= STAGES + 3; e++) begin
         @(posedge CLK);
         #1;
         check($sformatf("halt_o_edge%0d", e), 64'(bus.halt_o), 64'(e >= STAGES + 1));
         check($sformatf("halt_stall_edge%0d", e), 64'(bus.stall_o), 64'd1);
      end
`else
      // Opcode 0x3F is unknown without the halt feature: bubble, no stall, no halt
      drive_cycle(32'hFC000000, 1'b1, 1'b0, 1'b0, st);
      check("halt_op_stall", 64'(st), 64'd0);
      check("halt_op_ctrl",  64'(bus.ctrl_o), 64'({W_ADD, W_ADDI, Z}));
      check("halt_op_halt",  64'(bus.halt_o), 64'd0);
`endif

      // Asynchronous reset mid-cycle, away from any clock edge
      @(negedge CLK);
      bus.instr_valid_i = 1'b0; bus.mem_stall_i = 1'b0; bus.flush_i = 1'b0;
      #2 nRST = 1'b0;
      #1;
      check("async_rst_ctrl",  64'(bus.ctrl_o), 64'd0);
      check("async_rst_halt",  64'(bus.halt_o), 64'd0);
      check("async_rst_stall", 64'(bus.stall_o), 64'd0);
      @(negedge CLK);
      nRST = 1'b1;

      // Random traffic against the queue model
      reset_dut();
      for (int i = 0; i < 400; i++) begin
         logic [31:0] ins;
         logic v, ms, fl, urs, urt, hz;
         word_t w;
         ins = rnd_instr();
         v   = ($urandom_range(0, 9) != 0);
         ms  = ($urandom_range(0, 6) == 0);
         fl  = ($urandom_range(0, 9) == 0);
         ref_decode(ins, v, w, urs, urt);
         hz = m_q[0].v && m_q[0].ren && m_q[0].dst != 5'd0 &&
              ((urs && m_q[0].dst == ins[25:21]) || (urt && m_q[0].dst == ins[20:16]));
         drive_cycle(ins, v, ms, fl, st);
         check("rnd_stall", 64'(st), 64'(hz && !fl));
         if (!ms) begin
            m_q.push_front((fl || hz) ? word_t'('0) : w);
            void'(m_q.pop_back());
         end
         check("rnd_ctrl", 64'(bus.ctrl_o), 64'(pack_model()));
      end
      check("rnd_halt", 64'(bus.halt_o), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
